// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // S[3:2] operation class
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_SHR   = 2'b10;
  localparam logic [1:0] SEL_SHL   = 2'b11;

  localparam logic [3:0] OP_ADD = 4'b0000;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command, response and ALU-drive bundle of the sequencing controller.
interface alu_seq_ctrl_if #(parameter int W = 8, parameter int CNT_W = 3);
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [W-1:0]     cmd_a, cmd_b;
  logic             cmd_cin;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_acc;
  logic [W-1:0]     alu_a, alu_b;
  logic [3:0]       alu_s;
  logic             alu_cin;
  logic [W-1:0]     alu_d;
  logic             alu_cout, alu_z;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_d;
  logic             rsp_cout, rsp_z;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_cnt, cmd_acc,
    output alu_d, alu_cout, alu_z, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s, alu_cin,
    input  rsp_valid, rsp_d, rsp_cout, rsp_z, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_cnt, cmd_acc,
    input  alu_d, alu_cout, alu_z, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s, alu_cin,
    output rsp_valid, rsp_d, rsp_cout, rsp_z, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: drives an external combinational ALU from registers,
// iterates single-bit shifts, keeps an accumulator and returns the result.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_ctrl_if.slave bus
);
  logic [1:0]       rst_sync;
  logic             rst_i;
  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [W-1:0]     a_q, b_q, acc_q, d_q;
  logic             cin_q, cout_q, z_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, last, is_arith, exec;

  // Reset asserts immediately, releases two edges later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];

  assign exec     = (state == EXEC);
  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign last     = exec && (cnt_q == CNT_W'(1));
  assign is_arith = (op_q[3:2] == SEL_ARITH);

  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
      EXEC:    if (cnt_q == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      d_q    <= '0;
      cout_q <= 1'b0;
      z_q    <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.cmd_op;
      a_q   <= bus.cmd_acc ? acc_q : bus.cmd_a;
      b_q   <= bus.cmd_b;
      cin_q <= bus.cmd_cin;
      // cnt==0 on a shift, and every non-shift op, is a single pass
      cnt_q <= (bus.cmd_op[3] && bus.cmd_cnt != '0) ? bus.cmd_cnt : CNT_W'(1);
    end else if (exec) begin
      a_q   <= bus.alu_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last) begin
        d_q    <= bus.alu_d;
        acc_q  <= bus.alu_d;
        // ALU flags come from the arith unit only; derive them otherwise
        cout_q <= is_arith ? bus.alu_cout : 1'b0;
        z_q    <= is_arith ? bus.alu_z : (bus.alu_d == '0);
      end
    end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_d     = d_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_z     = z_q;
  assign bus.alu_a     = exec ? a_q   : '0;
  assign bus.alu_b     = exec ? b_q   : '0;
  assign bus.alu_s     = exec ? op_q  : 4'b0000;
  assign bus.alu_cin   = exec ? cin_q : 1'b0;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU beside the DUT, directed and random
// commands checked against a command-level reference model.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;
  localparam int W = 8, CNT_W = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus();
  alu_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // ALU instance stand-in: flags always come from the arith unit
  logic [W:0] arith;
  always_comb begin
    arith = '0;
    case (bus.alu_s[1:0])
      2'b00:   arith = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
      2'b01:   arith = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{W{1'b0}}, bus.alu_cin};
      2'b10:   arith = {1'b0, bus.alu_a} + {{W{1'b0}}, bus.alu_cin};
      default: arith = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    endcase
    bus.alu_cout = arith[W];
    bus.alu_z    = (arith[W-1:0] == '0);
    bus.alu_d    = '0;
    case (bus.alu_s[3:2])
      2'b00: bus.alu_d = arith[W-1:0];
      2'b01: case (bus.alu_s[1:0])
               2'b00:   bus.alu_d = bus.alu_a & bus.alu_b;
               2'b01:   bus.alu_d = bus.alu_a | bus.alu_b;
               2'b10:   bus.alu_d = bus.alu_a ^ bus.alu_b;
               default: bus.alu_d = ~bus.alu_a;
             endcase
      2'b10: bus.alu_d = bus.alu_a >> 1;
      default: bus.alu_d = bus.alu_a << 1;
    endcase
  end

  int tests = 0, fails = 0;
  logic [W-1:0] model_acc, e_a, e_d;
  logic [3:0]   e_op;
  logic         e_cout, e_z;
  int           e_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-command result from the operation rules
  task automatic drive_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [CNT_W-1:0] cnt, input logic acc);
    int sum;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cin = cin;
    bus.cmd_cnt = cnt; bus.cmd_acc = acc; bus.cmd_valid = 1'b1;
    e_op   = op;
    e_a    = acc ? model_acc : a;
    e_p    = (op[3] && cnt != 0) ? int'(cnt) : 1;
    e_cout = 1'b0;
    case (op[3:2])
      SEL_ARITH: begin
        sum    = int'(e_a) + int'(b) + int'(cin);
        e_d    = sum[W-1:0];
        e_cout = sum[W];
      end
      SEL_LOGIC: case (op[1:0])
        2'b00:   e_d = e_a & b;
        2'b01:   e_d = e_a | b;
        2'b10:   e_d = e_a ^ b;
        default: e_d = ~e_a;
      endcase
      SEL_SHR: e_d = e_a >> e_p;
      default: e_d = e_a << e_p;
    endcase
    e_z = (e_d == 0);
  endtask

  task automatic wait_accept;
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin step; n++; end
    chk("accept_ready", 32'(bus.cmd_ready), 1);
    step;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic exec_check(input string tag);
    logic [W-1:0] ea;
    for (int i = 0; i < e_p; i++) begin
      if (e_op[3:2] == SEL_SHR)      ea = e_a >> i;
      else if (e_op[3:2] == SEL_SHL) ea = e_a << i;
      else                           ea = e_a;
      chk({tag, "_busy"},   32'(bus.busy), 1);
      chk({tag, "_alu_a"},  32'(bus.alu_a), 32'(ea));
      chk({tag, "_early"},  32'(bus.rsp_valid), 0);
      step;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_d"},     32'(bus.rsp_d), 32'(e_d));
    chk({tag, "_cout"},  32'(bus.rsp_cout), 32'(e_cout));
    chk({tag, "_z"},     32'(bus.rsp_z), 32'(e_z));
    chk({tag, "_alu0"},  32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}), 0);
    model_acc = e_d;
  endtask

  task automatic handshake;
    bus.rsp_ready = 1'b1;
    step;
    bus.rsp_ready = 1'b0;
    chk("hs_valid", 32'(bus.rsp_valid), 0);
    chk("hs_ready", 32'(bus.cmd_ready), 1);
  endtask

  task automatic full(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin, input logic [CNT_W-1:0] cnt,
                      input logic acc);
    drive_cmd(op, a, b, cin, cnt, acc);
    wait_accept;
    exec_check(tag);
    handshake;
  endtask

  initial begin
    logic [W-1:0] hd;
    logic hc, hz;
    logic [1:0] cls;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_cin = 0;
    bus.cmd_cnt = 0; bus.cmd_acc = 0; bus.rsp_ready = 0;
    model_acc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step;
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp",   32'({bus.rsp_d, bus.rsp_cout, bus.rsp_z}), 0);
    chk("rst_alu",   32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}), 0);

    full("add",   OP_ADD,  8'h7F, 8'h01, 1'b0, 3'd0, 1'b0);
    full("addc",  OP_ADD,  8'hFF, 8'h01, 1'b0, 3'd0, 1'b0);
    full("shl3",  4'b1100, 8'h11, 8'h00, 1'b0, 3'd3, 1'b0);
    full("shr2",  4'b1000, 8'h01, 8'h00, 1'b0, 3'd2, 1'b0);
    full("acc0",  OP_ADD,  8'h05, 8'h00, 1'b0, 3'd0, 1'b0);
    full("acc1",  OP_ADD,  8'hAA, 8'h03, 1'b0, 3'd0, 1'b1);
    chk("acc1_const", 32'(bus.rsp_d), 32'h08);
    full("acc2",  4'b1000, 8'h33, 8'h00, 1'b0, 3'd1, 1'b1);
    chk("acc2_const", 32'(bus.rsp_d), 32'h04);

    // Backpressure: response held while a new command waits
    drive_cmd(4'b0110, 8'h3C, 8'hF0, 1'b0, 3'd0, 1'b0);
    wait_accept;
    exec_check("bp1");
    hd = e_d; hc = e_cout; hz = e_z;
    drive_cmd(4'b1100, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1);
    repeat (5) begin
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp",   32'({bus.rsp_d, bus.rsp_cout, bus.rsp_z}), 32'({hd, hc, hz}));
      chk("bp_ready", 32'(bus.cmd_ready), 0);
      step;
    end
    bus.rsp_ready = 1'b1;
    step;
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(bus.cmd_ready), 1);
    chk("bp_idle_busy",  32'(bus.busy), 0);
    wait_accept;
    exec_check("bp2");
    handshake;

    for (int k = 0; k < 40; k++) begin
      cls = 2'($urandom_range(0, 3));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      full("rnd", (cls == SEL_ARITH) ? OP_ADD : {cls, 2'($urandom_range(0, 3))},
           8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step;
    end

    // Reset during pass 3 of a 7-pass shift
    drive_cmd(4'b1100, 8'h01, 8'h00, 1'b0, 3'd7, 1'b0);
    wait_accept;
    step; step;
    chk("mid_alu_a", 32'(bus.alu_a), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(bus.cmd_ready), 1);
    chk("mid_busy",  32'(bus.busy), 0);
    chk("mid_alu",   32'(bus.alu_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_acc = '0;
    repeat (10) begin
      chk("mid_novalid", 32'(bus.rsp_valid), 0);
      step;
    end
    full("post_rst_acc", OP_ADD, 8'h99, 8'h05, 1'b0, 3'd0, 1'b1);
    chk("post_rst_const", 32'(bus.rsp_d), 32'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 8-bit data-flow ALU (`alu`). It accepts operation commands over a valid/ready handshake and drives the ALU's A/B/S/C_in inputs from registers. It iterates single-bit shift ops for multi-bit shifts, keeps a result accumulator for chained operations, and returns the captured result over a second valid/ready handshake. It sits between the command source and the ALU instance, which is instantiated beside it at the parent level.

## Interface
- `W`, 8: datapath width; must match the ALU.
- `CNT_W`, 3: width of the shift-count field.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 4: ALU select S. S[3:2]: 00 arith, 01 logic, 10 shift right (zero fill), 11 shift left.
- `cmd_a` / `cmd_b` in W: operands.
- `cmd_cin` in 1: carry-in for arithmetic ops.
- `cmd_cnt` in CNT_W: shift pass count. 0 means 1 pass; ignored for non-shift ops.
- `cmd_acc` in 1: use the accumulator instead of `cmd_a` as operand A.
- `alu_a`, `alu_b` out W; `alu_s` out 4; `alu_cin` out 1: ALU drive.
- `alu_d` in W; `alu_cout`, `alu_z` in 1: ALU results.
- `rsp_valid` out 1 / `rsp_ready` in 1: result handshake.
- `rsp_d` out W; `rsp_cout`, `rsp_z` out 1: result fields.
- `busy` out 1: high when the state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch op, b, cin and passes P (P = cnt for shifts with cnt≠0, else 1).
  - Latch A = `cmd_acc` ? acc : `cmd_a`.
  - Go to EXEC with pass counter = P.
- EXEC:
  - `alu_*` driven from the latched registers.
  - Each cycle: A register <= `alu_d`; decrement the pass counter.
  - When the counter reaches 1: capture the result, update acc <= `alu_d`, go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` fields held stable.
  - On `rsp_ready`, go to IDLE.
- Result flags:
  - Arith ops (S[3:2]=00): `rsp_cout`/`rsp_z` = `alu_cout`/`alu_z` sampled on the final pass.
  - Logic and shift ops: `rsp_cout`=0, `rsp_z`=(`alu_d`==0). The ALU's flags come only from the arithmetic unit, so they are not used for these ops.
- `cmd_ready`=0 outside IDLE. `cmd_valid` is ignored there; no queueing.
- In IDLE and RESP, `alu_a`, `alu_b`, `alu_s` and `alu_cin` are driven to 0.
- Arith encoding used by the bench: `cmd_op`=4'b0000 gives A+B+C_in.
- Widths:
  - Shifts never wrap; bits shifted out are lost.
  - Arith results are modulo 2^W, with carry reported in `rsp_cout`.

## Timing
- Reset (async assert, sync deassert inside the block):
  - State=IDLE; acc, A, B, op and the counter = 0.
  - `cmd_ready`=1, `busy`=0, `rsp_valid`=0, all `rsp_*`=0, all `alu_*`=0.
- Latency: accept at cycle 0; EXEC during cycles 1..P; `rsp_valid` high from cycle P+1.
- The ALU is combinational. `alu_d` is sampled at the end of each EXEC cycle; no ALU pipeline stage is assumed.
- `rsp_valid` & `rsp_ready` in the same cycle: state goes to IDLE and `cmd_ready`=1 the next cycle. Minimum command spacing is P+2 cycles.
- `rsp_ready` held high before `rsp_valid`: the handshake completes in the first RESP cycle.
- `rst_n` low mid-EXEC or in RESP:
  - The command is dropped and no response is issued.
  - acc returns to 0.
- `cmd_acc` on the first command after reset uses acc=0.

## Structure
- Shared package `alu_ctrl_pkg`:
  - state enum (IDLE/EXEC/RESP);
  - S[3:2] class constants SEL_ARITH=2'b00, SEL_LOGIC=2'b01, SEL_SHR=2'b10, SEL_SHL=2'b11;
  - OP_ADD=4'b0000.
- No sub-module is needed; the block is a single FSM plus registers.
- The ALU is not instantiated inside the block. The parent wires `alu_*` to an `alu` instance; the bench does the same.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Expect `cmd_ready`=1, `busy`=0, `rsp_valid`=0 and all `alu_*`=0.
- Add: op=0000, a=0x7F, b=0x01, cin=0. Expect `rsp_valid` at accept+2 with d=0x80, cout=0, z=0.
- Add with carry-out: a=0xFF, b=0x01. Expect d=0x00, cout=1, z=1.
- Multi-pass shift left: op=1100, a=0x11, cnt=3. Expect 3 EXEC cycles with `alu_a` = 0x11, 0x22, 0x44; rsp d=0x88, z=0, `rsp_valid` at accept+4.
- Shift right, all bits out: op=1000, a=0x01, cnt=2. Expect d=0x00, z=1, cout=0.
- Accumulate: add a=0x05, b=0x00 → 0x05; then `cmd_acc`=1, b=0x03 → 0x08; then shift right `cmd_acc`=1, cnt=1 → 0x04.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 and new data. Expect `rsp_*` stable, `cmd_ready`=0 and the new command not accepted. Release `rsp_ready`: the new command is accepted one cycle after the handshake.
- Reset mid-op: shift left cnt=7, assert `rst_n`=0 in pass 3. Expect no `rsp_valid`, acc=0 and `cmd_ready`=1 after release.
